// File: rtl/alu_sequencer_if.sv
// Request/completion bus between the ALU wrapper and the multi-cycle ALU sequencer.
// The master issues start/op_sel/a/b; the slave returns busy/done/result status.
interface alu_sequencer_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [1:0]         op_sel;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [1:0]         alu_op;
  logic [2*WIDTH-1:0] result;
  logic               div_by_zero;

  modport master (
    output start, op_sel, a, b,
    input  busy, done, alu_op, result, div_by_zero
  );

  modport slave (
    input  start, op_sel, a, b,
    output busy, done, alu_op, result, div_by_zero
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: single-step ADD/SUB, WIDTH-step shift-add MUL and
// restoring DIV, behind a start/busy/done handshake.
module alu_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  alu_sequencer_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic [1:0]         alu_op;
  logic [2*WIDTH-1:0] result;
  logic               div_by_zero;

  // opa: shifted multiplicand (MUL) or dividend/quotient in the low half (DIV)
  // opb: multiplier shifted right (MUL) or constant divisor (DIV)
  // acc: partial product (MUL) or partial remainder in the low half (DIV)
  logic [2*WIDTH-1:0] opa;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;

  logic [2*WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   div_rem_nxt;
  logic [WIDTH-1:0]   div_quot_nxt;
  logic               last;

  function automatic logic [2*WIDTH-1:0] add_sub(input logic sub,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] xe;
    logic [2*WIDTH-1:0] ye;
    xe = {{WIDTH{1'b0}}, x};
    ye = {{WIDTH{1'b0}}, y};
    return sub ? (xe - ye) : (xe + ye);
  endfunction

  always_comb begin
    mul_acc_nxt  = acc + (opb[0] ? opa : '0);
    div_trial    = {acc[WIDTH-1:0], opa[WIDTH-1]};
    div_ge       = (div_trial >= {1'b0, opb});
    div_diff     = div_trial - {1'b0, opb};
    div_rem_nxt  = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    div_quot_nxt = {opa[WIDTH-2:0], div_ge};
    last         = (count == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      count       <= '0;
      alu_op      <= 2'b00;
      result      <= '0;
      div_by_zero <= 1'b0;
      opa         <= '0;
      opb         <= '0;
      acc         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            alu_op      <= bus.op_sel;
            div_by_zero <= 1'b0;
            opa         <= {{WIDTH{1'b0}}, bus.a};
            opb         <= bus.b;
            acc         <= '0;
            count       <= '0;
            if (!bus.op_sel[1]) begin
              result <= add_sub(bus.op_sel[0], bus.a, bus.b);
              state  <= S_DONE;
            end else begin
              state  <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          count <= last ? '0 : count + 1'b1;
          if (!alu_op[0]) begin
            acc <= mul_acc_nxt;
            opa <= opa << 1;
            opb <= opb >> 1;
          end else begin
            acc[WIDTH-1:0] <= div_rem_nxt;
            opa[WIDTH-1:0] <= div_quot_nxt;
          end
          // Result only becomes visible once the final iteration lands.
          if (last) begin
            result      <= alu_op[0] ? {div_rem_nxt, div_quot_nxt} : mul_acc_nxt;
            div_by_zero <= alu_op[0] && (opb == '0);
            state       <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (state == S_EXEC) || (state == S_DONE);
  assign bus.done        = (state == S_DONE);
  assign bus.alu_op      = alu_op;
  assign bus.result      = result;
  assign bus.div_by_zero = div_by_zero;
endmodule
